pipelined_cla_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor. The operand is split into

---
 rtl/pipelined_cla_addsub_if.sv | 32 +++
 rtl/pipelined_cla_addsub.sv | 133 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and data bundle for pipelined_cla_addsub.
//   master : the producer/consumer side. It drives the operands, in_valid and out_ready.
//   slave  : the adder. It drives in_ready and the result fields.
// Signals:
//   in_valid/in_ready   input handshake; a, b, cin and sub are qualified by in_valid
//   out_valid/out_ready output handshake; s, cout, ovf and zero are qualified by out_valid
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are cut into GROUP-bit slices. Stage k resolves slice k with full
// lookahead, using the carry that stage k-1 registered. Operands that are not yet
// consumed, and sum slices that are already resolved, travel with the data. Every
// slice of a result therefore lines up at the last stage.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; flushes the pipe and clears the outputs
//   bus  slave side of pipelined_cla_addsub_if
//        (valid/ready in, a/b/cin/sub, valid/ready out, s/cout/ovf/zero)
// A single enable, en = ~out_valid | out_ready, advances or freezes the whole pipe.
// Latency is STAGES cycles and throughput is one result per cycle.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_cla_addsub_if.slave   bus
);
    localparam int STAGES = WIDTH / GROUP;

    // One pipeline stage: the operands (b already in effective form), the sum
    // bits resolved so far, and the carry out of the last resolved slice.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] be;
        logic [WIDTH-1:0] s;
    } stage_t;

    // Returns {carry_out, sum} for one slice.
    // Every carry is a sum of products of g/p and the slice carry-in, so the
    // slice contains no ripple path.
    function automatic logic [GROUP:0] cla_slice(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             c_in
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             acc;
        logic             term;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < GROUP; i++) begin
            // The carry-in propagated through p[0..i].
            term = c_in;
            for (int j = 0; j <= i; j++) term = term & p[j];
            acc = term;
            // g[j] propagated through p[j+1..i].
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    stage_t stg_q [STAGES];
    stage_t stg_d [STAGES];
    stage_t in_stage;
    logic   ovf_q;
    logic   zero_q;
    logic   ovf_d;
    logic   zero_d;
    logic   en;

    assign en          = ~stg_q[STAGES-1].valid | bus.out_ready;
    assign bus.in_ready = en;

    // Subtraction is a + ~b + 1, so it uses the same carry chain as addition.
    always_comb begin
        // NOTE: each variable gets a full default first, so no path through this block can infer a latch.
        in_stage       = '0;
        in_stage.valid = bus.in_valid;
        in_stage.carry = bus.sub ? 1'b1 : bus.cin;
        in_stage.a     = bus.a;
        in_stage.be    = bus.sub ? ~bus.b : bus.b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t src;
        stage_t nxt;
        if (k == 0) begin : g_first
            assign src = in_stage;
        end else begin : g_rest
            assign src = stg_q[k-1];
        end

        always_comb begin
            logic [GROUP:0] r;
            r                        = cla_slice(src.a[k*GROUP +: GROUP], src.be[k*GROUP +: GROUP], src.carry);
            nxt                      = src;
            nxt.s[k*GROUP +: GROUP]  = r[GROUP-1:0];
            nxt.carry                = r[GROUP];
        end

        assign stg_d[k] = nxt;
    end

    // The flags come from the fully aligned result that is about to enter the
    // output stage. They are registered together with that result.
    assign ovf_d  = (stg_d[STAGES-1].a[WIDTH-1] == stg_d[STAGES-1].be[WIDTH-1]) &
                    (stg_d[STAGES-1].s[WIDTH-1] != stg_d[STAGES-1].a[WIDTH-1]);
    assign zero_d = ~|stg_d[STAGES-1].s;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset along with the valid bits, because the visible outputs must read 0 after reset.
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            // NOTE: the stage registers use non-blocking assignments, so each stage samples the old value of the stage before it.
            stg_q  <= stg_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid = stg_q[STAGES-1].valid;
    assign bus.s         = stg_q[STAGES-1].s;
    assign bus.cout      = stg_q[STAGES-1].carry;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=32, GROUP=8, so latency is 4).
// The driver pushes the expected result when an operation is accepted. The monitor
// compares the head of the queue against every valid output cycle, which also
// proves the output stays stable under a stall. It pops the head when the output
// transfers.
module tb_pipelined_cla_addsub;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

    pipelined_cla_addsub #(.WIDTH(W), .GROUP(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [W+2:0] exp_q [$];   // {s, cout, ovf, zero}

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W:0]   w;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        longint       r;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            r  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            w  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = w[W-1:0];
            co = w[W];
            r  = longint'($signed(a)) + longint'($signed(b)) + longint'({63'd0, cin});
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {s, co, ov, (s == '0)};
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got s=0x%0h, expected no output", bus.s);
            end else begin
                check("result", {29'd0, bus.s, bus.cout, bus.ovf, bus.zero}, {29'd0, exp_q[0]});
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            if (!bus.out_ready) check("in_ready_stall", {63'd0, bus.in_ready}, 64'd0);
        end
    end

    // The driver tasks are entered just after a posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            n++;
        end
        if (acc) begin
            exp_q.push_back(model(a, b, cin, sub));
            n_in++;
        end else begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int cnt;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Directed cases. The first one also measures latency.
        fork
            issue(32'h0000_00FF, 32'h1, 1'b0, 1'b0);
            wait_valid(lat);
        join
        check("latency", 64'(lat), 64'd4);
        drain();
        issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        issue(32'h0000_0005, 32'h7, 1'b0, 1'b1);
        drain();

        // Back-to-back stream of 16: first result after 4 cycles, then one per cycle
        cnt = 0;
        fork
            for (int i = 0; i < 16; i++) issue($urandom, $urandom, 1'($urandom), 1'($urandom));
            begin
                wait_valid(lat);
                check("stream_latency", 64'(lat), 64'd4);
                repeat (15) begin
                    @(negedge clk);
                    if (bus.out_valid) cnt++;
                end
                check("stream_throughput", 64'(cnt), 64'd15);
            end
        join
        drain();

        // Backpressure mid-stream
        fork
            for (int i = 0; i < 14; i++) issue(pick(), pick(), 1'($urandom), 1'($urandom));
            begin
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random bubbles and random out_ready
        fork
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end else begin
                    issue(pick(), pick(), 1'($urandom), 1'($urandom));
                end
            end
            repeat (80) begin
                @(posedge clk);
                #1 bus.out_ready = 1'($urandom_range(0, 3) != 0);
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("count_in_out", 64'(n_out), 64'(n_in));

        // Reset while the pipe is full and the output is stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue($urandom, $urandom, 1'($urandom), 1'($urandom));
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("stall_full", {63'd0, bus.out_valid}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        n_in  = 0;
        n_out = 0;
        check("flush_outputs", {28'd0, bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero}, 64'd0);
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        fork
            issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
            wait_valid(lat);
        join
        check("post_reset_latency", 64'(lat), 64'd4);
        drain();
        check("post_reset_count", 64'(n_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
